// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, source ids,
// the request record and the round-robin pick.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESPOND
    } arb_state_e;

    typedef enum logic {
        SRC_INSTR,
        SRC_DATA
    } arb_source_e;

    // Request record at the default bus geometry (32-bit address, 256-byte line).
    typedef struct packed {
        logic [31:0]   addr;
        logic          we;
        logic [2047:0] wdata;
    } mem_request_t;

    // On a tie the source that was not granted last wins.
    function automatic arb_source_e rr_pick(
        input logic        instr_pending,
        input logic        data_pending,
        input arb_source_e last_grant
    );
        if (instr_pending && data_pending) begin
            return (last_grant == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        end
        if (data_pending) begin
            return SRC_DATA;
        end
        return SRC_INSTR;
    endfunction

endpackage

// File: rtl/memory_arbiter_request_slot.sv
// One-deep request slot for a single cache; refuses new requests while the
// source already has a request pending or being served.
module memory_arbiter_request_slot #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  busy,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [LINE_BITS-1:0]  req_wdata,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  we,
    output logic [LINE_BITS-1:0]  wdata
);

    // busy is low during the done cycle, so a request there is taken.
    logic accept;
    assign accept = load && !pending && !busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
            addr    <= '0;
            we      <= 1'b0;
            wdata   <= '0;
        end else if (accept) begin
            pending <= 1'b1;
            addr    <= req_addr;
            we      <= req_we;
            wdata   <= req_wdata;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between instruction and data cache line requests onto a
// single memory port, with a per-transaction timeout and one-cycle done pulses.
//
// state       | meaning
// ARB_IDLE    | no transaction on the bus; grant a pending slot if any
// ARB_BUSY    | o_mem_req high, waiting for i_mem_ready or timeout
// ARB_RESPOND | done pulse, read line and error for the winner
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BUS_WIDTH_BYTES = 256,
    parameter int TIMEOUT_CYCLES  = 255,
    localparam int LINE_BITS      = BUS_WIDTH_BYTES * 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_instr_req,
    input  logic [ADDR_WIDTH-1:0] i_instr_addr,
    output logic [LINE_BITS-1:0]  o_instr_rdata,
    output logic                  o_instr_done,
    input  logic                  i_data_req,
    input  logic                  i_data_we,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [LINE_BITS-1:0]  i_data_wdata,
    output logic [LINE_BITS-1:0]  o_data_rdata,
    output logic                  o_data_done,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [LINE_BITS-1:0]  o_mem_wdata,
    input  logic [LINE_BITS-1:0]  i_mem_rdata,
    input  logic                  i_mem_ready,
    output logic                  o_error
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e          state;
    arb_source_e         winner;
    arb_source_e         last_grant;
    logic [CNT_W-1:0]    timeout_cnt;
    logic [CNT_W-1:0]    cnt_next;

    logic                  instr_pending;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  instr_we;
    logic [LINE_BITS-1:0]  instr_wdata;
    logic                  data_pending;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  data_we;
    logic [LINE_BITS-1:0]  data_wdata;

    logic        any_pending;
    arb_source_e grant_src;
    logic        grant_now;
    logic        instr_busy;
    logic        data_busy;
    logic        finish;
    logic [LINE_BITS-1:0] resp_line;

    assign any_pending = instr_pending || data_pending;
    assign grant_src   = rr_pick(instr_pending, data_pending, last_grant);
    assign grant_now   = (state == ARB_IDLE) && any_pending;
    assign instr_busy  = (state == ARB_BUSY) && (winner == SRC_INSTR);
    assign data_busy   = (state == ARB_BUSY) && (winner == SRC_DATA);

    assign cnt_next  = (timeout_cnt == CNT_MAX) ? CNT_MAX : timeout_cnt + 1'b1;
    assign finish    = i_mem_ready || (cnt_next == CNT_MAX);
    // Writes and timed-out reads return an all-zero line.
    assign resp_line = (i_mem_ready && !o_mem_we) ? i_mem_rdata : '0;

    memory_arbiter_request_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_BITS  (LINE_BITS)
    ) u_instr_slot (
        .clock     (i_clock),
        .reset     (i_reset),
        .load      (i_instr_req),
        .clear     (grant_now && (grant_src == SRC_INSTR)),
        .busy      (instr_busy),
        .req_addr  (i_instr_addr),
        .req_we    (1'b0),
        .req_wdata ('0),
        .pending   (instr_pending),
        .addr      (instr_addr),
        .we        (instr_we),
        .wdata     (instr_wdata)
    );

    memory_arbiter_request_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_BITS  (LINE_BITS)
    ) u_data_slot (
        .clock     (i_clock),
        .reset     (i_reset),
        .load      (i_data_req),
        .clear     (grant_now && (grant_src == SRC_DATA)),
        .busy      (data_busy),
        .req_addr  (i_data_addr),
        .req_we    (i_data_we),
        .req_wdata (i_data_wdata),
        .pending   (data_pending),
        .addr      (data_addr),
        .we        (data_we),
        .wdata     (data_wdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= ARB_IDLE;
            winner        <= SRC_INSTR;
            last_grant    <= SRC_INSTR;
            timeout_cnt   <= '0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_instr_done  <= 1'b0;
            o_data_done   <= 1'b0;
            o_instr_rdata <= '0;
            o_data_rdata  <= '0;
            o_error       <= 1'b0;
        end else begin
            // Response outputs are single-cycle; they are set only on BUSY exit.
            o_instr_done  <= 1'b0;
            o_data_done   <= 1'b0;
            o_instr_rdata <= '0;
            o_data_rdata  <= '0;
            o_error       <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (any_pending) begin
                        winner      <= grant_src;
                        last_grant  <= grant_src;
                        timeout_cnt <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_addr  <= (grant_src == SRC_DATA) ? data_addr  : instr_addr;
                        o_mem_we    <= (grant_src == SRC_DATA) ? data_we    : instr_we;
                        o_mem_wdata <= (grant_src == SRC_DATA) ? data_wdata : instr_wdata;
                        state       <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    timeout_cnt <= cnt_next;
                    if (finish) begin
                        o_mem_req <= 1'b0;
                        o_error   <= !i_mem_ready;
                        if (winner == SRC_INSTR) begin
                            o_instr_done  <= 1'b1;
                            o_instr_rdata <= resp_line;
                        end else begin
                            o_data_done  <= 1'b1;
                            o_data_rdata <= resp_line;
                        end
                        state <= ARB_RESPOND;
                    end
                end
                ARB_RESPOND: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LB = 2048;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_instr_req;
    logic [AW-1:0] i_instr_addr;
    logic [LB-1:0] o_instr_rdata;
    logic          o_instr_done;
    logic          i_data_req;
    logic          i_data_we;
    logic [AW-1:0] i_data_addr;
    logic [LB-1:0] i_data_wdata;
    logic [LB-1:0] o_data_rdata;
    logic          o_data_done;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [LB-1:0] o_mem_wdata;
    logic [LB-1:0] i_mem_rdata;
    logic          i_mem_ready;
    logic          o_error;

    always #5 clk = ~clk;

    memory_arbiter #(
        .ADDR_WIDTH      (AW),
        .BUS_WIDTH_BYTES (LB / 8),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_instr_req   (i_instr_req),
        .i_instr_addr  (i_instr_addr),
        .o_instr_rdata (o_instr_rdata),
        .o_instr_done  (o_instr_done),
        .i_data_req    (i_data_req),
        .i_data_we     (i_data_we),
        .i_data_addr   (i_data_addr),
        .i_data_wdata  (i_data_wdata),
        .o_data_rdata  (o_data_rdata),
        .o_data_done   (o_data_done),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_ready   (i_mem_ready),
        .o_error       (o_error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // memory responder state
    bit in_txn     = 0;
    int wait_cnt   = 0;
    int mem_delay  = 0;
    bit idle_noise = 0;

    // event logs
    bit            prev_req = 0;
    int            g_cyc[$];
    logic [AW-1:0] g_addr[$];
    int            d_cyc[$];
    int            d_src[$];

    // transaction-level model
    bit           model_on = 0;
    bit           m_out[2];
    bit           m_granted[2];
    int           m_issue[2];
    mem_request_t m_req[2];
    int           m_last, m_src, m_rise, m_high, m_free;
    bit           m_active, m_err;

    typedef struct {
        bit            src;
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    wbyte;
        int            delay;
        int            exp_high;
        bit            exp_err;
    } single_t;

    function automatic logic [LB-1:0] line_of(input logic [AW-1:0] a);
        return {{63{a ^ 32'hc3a5_0f1e}}, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        logic [LB-1:0] a, e;
        a = act;
        e = exp;
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got ..%016h expected ..%016h (low 64 bits)", name, a[63:0], e[63:0]);
        end
    endtask

    task automatic model_step();
        bit e0, e1;
        int w, d;
        bit exp_req, exp_done;
        logic [LB-1:0] exp_line;
        if (!m_active && cyc >= m_free) begin
            e0 = m_out[0] && !m_granted[0] && (m_issue[0] <= cyc - 2);
            e1 = m_out[1] && !m_granted[1] && (m_issue[1] <= cyc - 2);
            if (e0 || e1) begin
                w = (e0 && e1) ? ((m_last == 0) ? 1 : 0) : (e1 ? 1 : 0);
                d = $urandom_range(0, 6);
                mem_delay    = d;
                m_active     = 1;
                m_src        = w;
                m_rise       = cyc;
                m_granted[w] = 1;
                m_last       = w;
                m_high       = (d < TO) ? d + 1 : TO;
                m_err        = (d >= TO);
            end
        end
        exp_req  = m_active && (cyc < m_rise + m_high);
        exp_done = m_active && (cyc == m_rise + m_high);
        chk($sformatf("rnd_req@%0d", cyc), 64'(o_mem_req), 64'(exp_req));
        if (exp_req) begin
            chk($sformatf("rnd_addr@%0d", cyc), 64'(o_mem_addr), 64'(m_req[m_src].addr));
            chk($sformatf("rnd_we@%0d", cyc), 64'(o_mem_we), 64'(m_req[m_src].we));
            chk_line($sformatf("rnd_wdata@%0d", cyc), o_mem_wdata, m_req[m_src].wdata);
        end
        chk($sformatf("rnd_idone@%0d", cyc), 64'(o_instr_done), 64'(exp_done && m_src == 0));
        chk($sformatf("rnd_ddone@%0d", cyc), 64'(o_data_done), 64'(exp_done && m_src == 1));
        chk($sformatf("rnd_err@%0d", cyc), 64'(o_error), 64'(exp_done && m_err));
        if (exp_done) begin
            exp_line = (m_req[m_src].we || m_err) ? '0 : line_of(m_req[m_src].addr);
            chk_line($sformatf("rnd_rdata@%0d", cyc), (m_src == 0) ? o_instr_rdata : o_data_rdata, exp_line);
            chk_line($sformatf("rnd_other_rdata@%0d", cyc), (m_src == 0) ? o_data_rdata : o_instr_rdata, '0);
            m_active     = 0;
            m_out[m_src] = 0;
            m_free       = cyc + 2;
        end else begin
            chk_line($sformatf("rnd_rdata_idle@%0d", cyc), o_instr_rdata | o_data_rdata, '0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        i_instr_req = 1'b0;
        i_data_req  = 1'b0;
        if (o_instr_done || o_data_done)
            chk($sformatf("done_overlap@%0d", cyc), 64'(o_instr_done & o_data_done), 64'd0);
        if (o_mem_req && !prev_req) begin
            g_cyc.push_back(cyc);
            g_addr.push_back(o_mem_addr);
        end
        prev_req = o_mem_req;
        if (o_instr_done) begin d_cyc.push_back(cyc); d_src.push_back(0); end
        if (o_data_done)  begin d_cyc.push_back(cyc); d_src.push_back(1); end
        if (model_on) model_step();
        if (o_mem_req) begin
            if (!in_txn) begin
                in_txn   = 1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            i_mem_ready = (wait_cnt == mem_delay);
        end else begin
            in_txn      = 0;
            i_mem_ready = idle_noise && ($urandom_range(0, 3) == 0);
        end
        i_mem_rdata = (i_mem_ready && o_mem_req) ? line_of(o_mem_addr) : {64{32'hbad0_bad0}};
    endtask

    task automatic clear_logs();
        g_cyc.delete();
        g_addr.delete();
        d_cyc.delete();
        d_src.delete();
    endtask

    task automatic issue_instr(input logic [AW-1:0] a);
        i_instr_req  = 1'b1;
        i_instr_addr = a;
    endtask

    task automatic issue_data(input bit we, input logic [AW-1:0] a, input logic [LB-1:0] wd);
        i_data_req   = 1'b1;
        i_data_we    = we;
        i_data_addr  = a;
        i_data_wdata = wd;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        step();
        chk("rst_mem_req", 64'(o_mem_req), 64'd0);
        chk("rst_dones", 64'({o_instr_done, o_data_done, o_error, o_mem_we}), 64'd0);
        chk("rst_addr", 64'(o_mem_addr), 64'd0);
        chk_line("rst_rdata", o_instr_rdata | o_data_rdata | o_mem_wdata, '0);
        i_reset = 1'b0;
        clear_logs();
    endtask

    task automatic chk_grant(input string n, input int i, input int ec, input logic [AW-1:0] ea);
        if (g_cyc.size() <= i) chk({n, "_missing"}, 64'd0, 64'd1);
        else begin
            chk({n, "_cyc"}, 64'(g_cyc[i]), 64'(ec));
            chk({n, "_addr"}, 64'(g_addr[i]), 64'(ea));
        end
    endtask

    task automatic chk_done(input string n, input int i, input int ec, input int es);
        if (d_cyc.size() <= i) chk({n, "_missing"}, 64'd0, 64'd1);
        else begin
            chk({n, "_cyc"}, 64'(d_cyc[i]), 64'(ec));
            chk({n, "_src"}, 64'(d_src[i]), 64'(es));
        end
    endtask

    task automatic run_single(input single_t v, input string tag);
        int c0, hi;
        bit done_seen;
        logic [LB-1:0] wd, exp_wd, exp_rd;
        wd        = {256{v.wbyte}};
        exp_wd    = v.src ? wd : '0;
        exp_rd    = (v.we || v.exp_err) ? '0 : line_of(v.addr);
        mem_delay = v.delay;
        c0        = cyc;
        hi        = 0;
        done_seen = 0;
        if (v.src) issue_data(v.we, v.addr, wd);
        else issue_instr(v.addr);
        for (int k = 0; k < 20 && !done_seen; k++) begin
            step();
            if (o_mem_req) begin
                hi++;
                if (hi == 1) begin
                    chk({tag, "_rise_cyc"}, 64'(cyc), 64'(c0 + 2));
                    chk({tag, "_addr"}, 64'(o_mem_addr), 64'(v.addr));
                    chk({tag, "_we"}, 64'(o_mem_we), 64'(v.we));
                    chk_line({tag, "_wdata"}, o_mem_wdata, exp_wd);
                end
            end
            if (o_instr_done || o_data_done) begin
                done_seen = 1;
                chk({tag, "_done_cyc"}, 64'(cyc), 64'(c0 + 2 + v.exp_high));
                chk({tag, "_req_cycles"}, 64'(hi), 64'(v.exp_high));
                chk({tag, "_done_src"}, 64'({o_instr_done, o_data_done}), v.src ? 64'd1 : 64'd2);
                chk({tag, "_error"}, 64'(o_error), 64'(v.exp_err));
                chk_line({tag, "_rdata"}, v.src ? o_data_rdata : o_instr_rdata, exp_rd);
            end
        end
        if (!done_seen) chk({tag, "_no_done"}, 64'd0, 64'd1);
        step();
    endtask

    single_t tbl[7];
    int      c0, c1;

    initial begin
        i_reset      = 1'b1;
        i_instr_req  = 1'b0;
        i_instr_addr = '0;
        i_data_req   = 1'b0;
        i_data_we    = 1'b0;
        i_data_addr  = '0;
        i_data_wdata = '0;
        i_mem_rdata  = '0;
        i_mem_ready  = 1'b0;

        tbl[0] = '{0, 0, 32'h0000_1000, 8'h00, 0, 1, 0};
        tbl[1] = '{1, 0, 32'h0000_2040, 8'h3c, 2, 3, 0};
        tbl[2] = '{1, 1, 32'h0000_3000, 8'ha5, 1, 2, 0};
        tbl[3] = '{0, 0, 32'h0000_4400, 8'h00, 3, 4, 0};
        tbl[4] = '{0, 0, 32'h0000_5000, 8'h00, 7, 4, 1};
        tbl[5] = '{1, 1, 32'h0000_6000, 8'h5a, 9, 4, 1};
        tbl[6] = '{0, 0, 32'h0000_7080, 8'h00, 0, 1, 0};

        do_reset();

        for (int i = 0; i < 7; i++) run_single(tbl[i], $sformatf("vec%0d", i));

        // tie after reset: data first, then instr; a second tie goes to data again
        do_reset();
        mem_delay = 0;
        c0 = cyc;
        issue_instr(32'h100);
        issue_data(1'b0, 32'h200, '0);
        repeat (8) step();
        chk_grant("tie1_g0", 0, c0 + 2, 32'h200);
        chk_grant("tie1_g1", 1, c0 + 5, 32'h100);
        chk_done("tie1_d0", 0, c0 + 3, 1);
        chk_done("tie1_d1", 1, c0 + 6, 0);
        chk("tie1_ngrant", 64'(g_cyc.size()), 64'd2);
        clear_logs();
        c0 = cyc;
        issue_instr(32'h110);
        issue_data(1'b0, 32'h210, '0);
        repeat (8) step();
        chk_grant("tie2_g0", 0, c0 + 2, 32'h210);
        chk_grant("tie2_g1", 1, c0 + 5, 32'h110);
        issue_data(1'b0, 32'h220, '0);
        repeat (5) step();
        clear_logs();
        c0 = cyc;
        issue_instr(32'h120);
        issue_data(1'b0, 32'h230, '0);
        repeat (8) step();
        chk_grant("tie3_g0", 0, c0 + 2, 32'h120);
        chk_grant("tie3_g1", 1, c0 + 5, 32'h230);

        // repeated req while outstanding is dropped; req in done cycle is taken
        clear_logs();
        mem_delay = 2;
        c0 = cyc;
        issue_instr(32'h400);
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k <= 4) issue_instr(32'h500 + 32'(k * 16));
            if (k == 5) issue_instr(32'h700);
        end
        chk("rep_ngrant", 64'(g_cyc.size()), 64'd2);
        chk_grant("rep_g0", 0, c0 + 2, 32'h400);
        chk_grant("rep_g1", 1, c0 + 7, 32'h700);
        chk_done("rep_d0", 0, c0 + 5, 0);
        chk_done("rep_d1", 1, c0 + 10, 0);

        // reset in the middle of BUSY discards everything
        clear_logs();
        mem_delay = 9;
        c0 = cyc;
        issue_instr(32'h800);
        step();
        issue_data(1'b0, 32'h880, '0);
        step();
        step();
        i_reset = 1'b1;
        step();
        chk("midrst_req", 64'(o_mem_req), 64'd0);
        chk("midrst_outs", 64'({o_instr_done, o_data_done, o_error, o_mem_we}), 64'd0);
        chk("midrst_addr", 64'(o_mem_addr), 64'd0);
        i_reset = 1'b0;
        repeat (6) step();
        chk("midrst_ngrant", 64'(g_cyc.size()), 64'd1);
        chk("midrst_ndone", 64'(d_cyc.size()), 64'd0);
        mem_delay = 0;
        c1 = cyc;
        issue_instr(32'h900);
        repeat (5) step();
        chk_grant("midrst_g1", 1, c1 + 2, 32'h900);
        chk_done("midrst_d0", 0, c1 + 3, 0);

        // randomized traffic against the transaction model
        do_reset();
        m_out      = '{0, 0};
        m_granted  = '{0, 0};
        m_issue    = '{0, 0};
        m_last     = 0;
        m_active   = 0;
        m_free     = cyc;
        model_on   = 1;
        idle_noise = 1;
        for (int k = 0; k < 2500; k++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                if (!m_out[s] && $urandom_range(0, 2) == 0) begin
                    m_out[s]          = 1;
                    m_granted[s]      = 0;
                    m_issue[s]        = cyc;
                    m_req[s].addr     = $urandom;
                    m_req[s].we       = (s == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    m_req[s].wdata    = (s == 1) ? {64{$urandom}} : '0;
                    if (s == 0) issue_instr(m_req[s].addr);
                    else issue_data(m_req[s].we, m_req[s].addr, m_req[s].wdata);
                end else if (m_out[s] && $urandom_range(0, 5) == 0) begin
                    if (s == 0) issue_instr($urandom);
                    else issue_data(1'b1, $urandom, {64{$urandom}});
                end
            end
        end
        model_on = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester memory bus arbiter between the instruction cache and the data cache on one side and the memory management unit's single memory port on the other. Each cache posts one line request (the instruction cache reads only; the data cache reads or writes). The arbiter queues one request per source, grants the port round-robin, holds the transaction until memory completes or a timeout fires, then returns a one-cycle done pulse with the read line.

## Interface
- ADDR_WIDTH, 32, byte address width.
- BUS_WIDTH_BYTES, 256, line and bus width in bytes; data width is LINE_BITS = BUS_WIDTH_BYTES*8.
- TIMEOUT_CYCLES, 255, maximum cycles a granted transaction waits for i_mem_ready; must be ≥ 1.
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_instr_req  in  1  one-cycle request pulse from the instruction cache (read).
- i_instr_addr  in  ADDR_WIDTH  line address; sampled with i_instr_req.
- o_instr_rdata  out  LINE_BITS  read line; valid while o_instr_done = 1.
- o_instr_done  out  1  one-cycle completion pulse.
- i_data_req  in  1  one-cycle request pulse from the data cache.
- i_data_we  in  1  1 = write-back, 0 = refill; sampled with i_data_req.
- i_data_addr  in  ADDR_WIDTH  line address; sampled with i_data_req.
- i_data_wdata  in  LINE_BITS  write line; sampled with i_data_req.
- o_data_rdata  out  LINE_BITS  read line; valid while o_data_done = 1.
- o_data_done  out  1  one-cycle completion pulse.
- o_mem_req  out  1  transaction active toward memory.
- o_mem_we  out  1  write enable of the active transaction.
- o_mem_addr  out  ADDR_WIDTH  address of the active transaction.
- o_mem_wdata  out  LINE_BITS  write data of the active transaction.
- i_mem_rdata  in  LINE_BITS  read data; valid when i_mem_ready = 1.
- i_mem_ready  in  1  memory completion; sampled only while o_mem_req = 1.
- o_error  out  1  pulses together with a done pulse when that transaction timed out.

## Operation
- Each source has one request slot holding pending, addr, we, wdata.
- A req pulse loads the slot only if that source has nothing outstanding. Outstanding means pending, granted, or in its done cycle. A second req while outstanding is ignored.
- Exception: a req in the same cycle as that source's done pulse is accepted.
- States: ARB_IDLE, ARB_BUSY, ARB_RESPOND.
- ARB_IDLE, at least one slot pending:
  - Pick the winner. If both are pending, the source not granted last wins. last_grant resets to INSTR, so the first tie goes to DATA.
  - Copy the winner's slot to o_mem_* with o_mem_req = 1, clear its pending flag, update last_grant, clear the timeout counter, go to ARB_BUSY.
- ARB_BUSY:
  - o_mem_* held stable and the counter increments each cycle.
  - i_mem_ready = 1: capture i_mem_rdata (writes capture zeros), drop o_mem_req, go to ARB_RESPOND.
  - Counter reaches TIMEOUT_CYCLES without ready: drop o_mem_req, capture zeros, set the error flag, go to ARB_RESPOND.
  - If ready and timeout coincide, ready wins with no error.
- ARB_RESPOND: assert the winner's done, its rdata and o_error (error flag) for one cycle, then go to ARB_IDLE. A request pending from the other source is granted on the next ARB_IDLE cycle.
- Width rules:
  - Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - rdata outputs are zero when done = 0.

## Timing
- Reset values: all outputs 0; state ARB_IDLE; both slots empty; last_grant = INSTR; counter and error flag 0.
- Reset during any state wins the next edge and drops o_mem_req. In-flight and pending requests are discarded with no done pulse.
- Best-case latency, req pulse in cycle 0 with the arbiter idle:
  - slot loaded at edge 1; grant decided in ARB_IDLE during cycle 1; o_mem_req high in cycle 2.
  - i_mem_ready high in cycle 2 gives done in cycle 3.
  - Read latency = 3 + (memory wait cycles).
- Minimum bus-turnaround gap between transactions is 2 cycles: RESPOND, then IDLE.
- Timeout: with no i_mem_ready, o_mem_req stays high exactly TIMEOUT_CYCLES cycles.
- Done pulses never overlap; at most one source completes per cycle.

## Structure
- Add to pkg_defines:
  - typedef enum arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESPOND}.
  - typedef enum arb_source_e {SRC_INSTR, SRC_DATA}.
  - struct mem_request_t {addr, we, wdata}.
- Sub-module arb_request_slot, instantiated twice:
  - Ports: clock, reset, load, clear, request in, pending and request out.
  - Holds the outstanding guard logic.
- Top holds the FSM, round-robin flop, timeout counter and response registers.

## Test plan
- Instruction read, ready in the first BUSY cycle: req at cycle 0, addr 0x1000 → o_mem_req cycles 2–2, addr 0x1000, we 0; o_instr_done at cycle 3 with rdata equal to the memory line.
- Simultaneous req from both after reset: data is granted first, instr next; two done pulses, data then instr, 2 cycles apart minimum; the next tie goes to data again only after an instr grant.
- Data write-back: we = 1, wdata pattern 0xA5 repeated → o_mem_we = 1, o_mem_wdata matches; o_data_rdata = 0 at done.
- TIMEOUT_CYCLES = 4, memory never ready → o_mem_req high exactly 4 cycles; done with o_error = 1, rdata 0; the next request proceeds normally.
- Repeated i_instr_req while outstanding is ignored (single transaction); req in the done cycle is accepted and issued.
- i_reset asserted mid-BUSY → outputs 0 next cycle, no done; a new request after release completes normally.
